// File: rtl/i2s_pkg.sv
// Shared I2S constants and PCM sample type, used by the receiver, the
// microphone emulator and the sample RAM writer.
package i2s_pkg;

  localparam int PCM_W           = 24;
  localparam int I2S_DUMMY_SLOTS = 1;
  localparam int I2S_BITS_PER_CH = 32;
  localparam int I2S_LAST_SLOT   = I2S_DUMMY_SLOTS + PCM_W - 1;

  typedef logic signed [PCM_W-1:0] pcm_sample_t;

endpackage

// File: rtl/i2s_rx_master_if.sv
// PCM pair stream between the I2S receiver and the sample buffer.
interface i2s_rx_master_if;
  import i2s_pkg::*;

  pcm_sample_t left;
  pcm_sample_t right;
  logic        valid;
  logic        ready;

  modport master (output left, output right, output valid, input ready);
  modport slave  (input left, input right, input valid, output ready);

endinterface

// File: rtl/i2s_clk_gen.sv
// SCK/WS generator: clock divider, bit slot counter and the SCK rise strobe.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV     = 8,
  parameter int BITS_PER_CH = I2S_BITS_PER_CH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  output logic                           sck,
  output logic                           ws,
  output logic                           rise_tick,
  output logic [$clog2(BITS_PER_CH)-1:0] bit_cnt
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(BITS_PER_CH);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             fall_tick;

  assign tick      = en_i && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick = tick && !sck;
  assign fall_tick = tick && sck;

  // Disable behaves like reset so every enable starts a fresh frame on the left channel.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        sck     <= !sck;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall_tick) begin
        if (bit_cnt == BIT_W'(BITS_PER_CH - 1)) begin
          bit_cnt <= '0;
          ws      <= !ws;
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/i2s_rx_master.sv
// I2S bus master/receiver: drives SCK/WS, deserializes SD into signed
// 24-bit left/right pairs and offers them on a valid/ready stream.
module i2s_rx_master
  import i2s_pkg::*;
#(
  parameter int CLK_DIV     = 8,
  parameter int BITS_PER_CH = I2S_BITS_PER_CH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    sd_i,
  output logic                    sck_o,
  output logic                    ws_o,
  output logic                    overrun_o,
  i2s_rx_master_if.master         pcm
);

  localparam int BIT_W = $clog2(BITS_PER_CH);

  logic             rise_tick;
  logic [BIT_W-1:0] bit_cnt;

  i2s_clk_gen #(
    .CLK_DIV     (CLK_DIV),
    .BITS_PER_CH (BITS_PER_CH)
  ) u_clk_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .sck       (sck_o),
    .ws        (ws_o),
    .rise_tick (rise_tick),
    .bit_cnt   (bit_cnt)
  );

  // Stage p0/p1: two-flop synchronizer for the asynchronous SD pin.
  logic sd_p0;
  logic sd_p1;

  always_ff @(posedge clk_i) begin
    sd_p0 <= sd_i;
    sd_p1 <= sd_p0;
  end

  // Stage p2: shift register, left hold and the output pair register.
  pcm_sample_t shift_p2;
  pcm_sample_t left_hold;
  pcm_sample_t shift_next;
  logic        data_slot;
  logic        last_slot;
  logic        pair_done;
  logic        load_pair;

  assign shift_next = {shift_p2[PCM_W-2:0], sd_p1};
  assign data_slot  = rise_tick && (bit_cnt >= BIT_W'(I2S_DUMMY_SLOTS))
                                && (bit_cnt <= BIT_W'(I2S_LAST_SLOT));
  assign last_slot  = rise_tick && (bit_cnt == BIT_W'(I2S_LAST_SLOT));
  assign pair_done  = last_slot && ws_o;
  assign load_pair  = pair_done && (!pcm.valid || pcm.ready);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_p2  <= '0;
      left_hold <= '0;
      pcm.left  <= '0;
      pcm.right <= '0;
      pcm.valid <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (!en_i) begin
        shift_p2 <= '0;
      end else if (data_slot) begin
        shift_p2 <= shift_next;
      end
      if (last_slot && !ws_o) begin
        left_hold <= shift_next;
      end
      // A pair arriving while the previous one is still unaccepted is dropped.
      if (load_pair) begin
        pcm.left  <= left_hold;
        pcm.right <= shift_next;
      end else if (pair_done) begin
        overrun_o <= 1'b1;
      end
      if (load_pair) begin
        pcm.valid <= 1'b1;
      end else if (pcm.valid && pcm.ready) begin
        pcm.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_master.sv
// Bench for i2s_rx_master: time-based I2S transmitter/receiver model plus
// directed scenarios and randomized pairs with random backpressure.
module tb_i2s_rx_master;
  import i2s_pkg::*;

  localparam int CD    = 4;
  localparam int BPC   = 32;
  localparam int PER   = 2 * CD;
  localparam int FRAME = 2 * BPC * PER;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic sd  = 1'b0;
  logic sck, ws, ovr;

  i2s_rx_master_if pcm ();

  i2s_rx_master #(.CLK_DIV(CD), .BITS_PER_CH(BPC)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .sd_i      (sd),
    .sck_o     (sck),
    .ws_o      (ws),
    .overrun_o (ovr),
    .pcm       (pcm)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (transmitter + expected outputs) ----
  pair_t       tx_q[$];
  pair_t       cur;
  logic        pending = 1'b0;
  int          t = 0;
  logic        rst_u = 1'b1, en_u = 1'b1, rdy_u = 1'b0;
  logic        started = 1'b0;
  logic        e_valid = 1'b0, e_ovr = 1'b0, v0;
  logic [23:0] e_left = '0, e_right = '0;
  int          m, slot, ch;

  always @(negedge clk) begin
    // Advance the model over the posedge that just occurred.
    if (rst_u) begin
      t = 0; pending = 1'b0; started = 1'b1;
      e_valid = 1'b0; e_ovr = 1'b0; e_left = '0; e_right = '0;
    end else begin
      if (!en_u) begin
        t = 0; pending = 1'b0;
      end else begin
        t++;
      end
      v0 = e_valid;
      if (v0 && rdy_u) e_valid = 1'b0;
      if (en_u && pending && (t % PER == CD) && ((t / PER) % BPC == 24)
          && (((t / PER) / BPC) % 2 == 1)) begin
        pending = 1'b0;
        if (!v0 || rdy_u) begin
          e_left = cur.l; e_right = cur.r; e_valid = 1'b1;
        end else begin
          e_ovr = 1'b1;
        end
      end
    end
    // Transmitter: a new bit slot starts at every SCK fall.
    if (t % PER == 0) begin
      m = t / PER; slot = m % BPC; ch = (m / BPC) % 2;
      if (started && slot == 1 && ch == 0) begin
        if (tx_q.size() > 0) cur = tx_q.pop_front();
        else cur = {24'($urandom), 24'($urandom)};
        pending = 1'b1;
      end
      if (slot >= 1 && slot <= 24) sd = (ch == 1) ? cur.r[24 - slot] : cur.l[24 - slot];
      else sd = 1'b0;
    end
    if (started) begin
      check("cycle", {12'h0, sck, ws, pcm.valid, ovr, pcm.left, pcm.right},
            {12'h0, 1'((t / CD) % 2), 1'(((t / PER) / BPC) % 2), e_valid, e_ovr,
             e_left, e_right});
    end
    rst_u = rst; en_u = en; rdy_u = pcm.ready;
  end

  // ---------------- stimulus and literal checks ---------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_valid(input string name, input int max);
    int k = 0;
    while (pcm.valid !== 1'b1 && k < max) begin
      tick(1);
      k++;
    end
    check(name, {63'h0, pcm.valid}, 64'h1);
  endtask

  task automatic wait_ws(input logic lvl, input string name);
    int k = 0;
    while (ws !== lvl && k < FRAME) begin
      tick(1);
      k++;
    end
    check(name, {63'h0, ws}, {63'h0, lvl});
  endtask

  initial begin
    int n;
    pcm.ready = 1'b1;
    tx_q.push_back('{24'h7FFFFF, 24'h800000});

    // Reset held for 5 cycles with enable high.
    tick(5);
    check("rst_outputs", {sck, ws, pcm.valid, ovr, pcm.left, pcm.right}, 52'h0);
    rst = 1'b0;
    n = 0;
    while (sck !== 1'b1 && n < 100) begin tick(1); n++; end
    check("first_rise", 64'(n), 64'(CD));
    while (ws !== 1'b1 && n < 1000) begin tick(1); n++; end
    check("first_ws_edge", 64'(n), 64'(PER * BPC));

    // Single pair, full-scale values.
    wait_valid("pair0_wait", FRAME);
    check("pair0_left", $signed(pcm.left), 64'(8388607));
    check("pair0_right", $signed(pcm.right), 64'(-8388608));
    tick(1);
    check("pair0_pulse", {63'h0, pcm.valid}, 64'h0);

    // Backpressure over two frames.
    pcm.ready = 1'b0;
    tx_q.push_back('{24'h13579B, 24'h2468AC});
    tx_q.push_back('{24'h0F0F0F, 24'hF0F0F0});
    n = 0;
    while (ovr !== 1'b1 && n < 2 * FRAME + 100) begin tick(1); n++; end
    check("bp_overrun", {63'h0, ovr}, 64'h1);
    check("bp_valid", {63'h0, pcm.valid}, 64'h1);
    check("bp_left", $unsigned(pcm.left), 64'h13579B);
    check("bp_right", $unsigned(pcm.right), 64'h2468AC);
    pcm.ready = 1'b1;
    tick(1);
    check("bp_release", {63'h0, pcm.valid}, 64'h0);

    // Enable drop in the middle of the right channel.
    tx_q.push_back('{24'hABCDEF, 24'h654321});
    wait_ws(1'b0, "en_ws_low");
    wait_ws(1'b1, "en_ws_high");
    tick(10 * PER);
    en = 1'b0;
    tick(1);
    check("en_drop_clk", {62'h0, sck, ws}, 64'h0);
    tick(200);
    check("en_drop_novalid", {63'h0, pcm.valid}, 64'h0);
    tx_q.delete();
    tx_q.push_back('{24'h123456, 24'hFEDCBA});
    en = 1'b1;
    wait_valid("reen_wait", FRAME + 100);
    check("reen_left", $unsigned(pcm.left), 64'h123456);
    check("reen_right", $unsigned(pcm.right), 64'hFEDCBA);
    tick(1);

    // Reset at left bit 12.
    wait_ws(1'b1, "rst_ws_high");
    wait_ws(1'b0, "rst_ws_low");
    tick(12 * PER);
    rst = 1'b1;
    tick(1);
    check("midrst_outputs", {sck, ws, pcm.valid, ovr, pcm.left, pcm.right}, 52'h0);
    tx_q.delete();
    tx_q.push_back('{24'h000001, 24'hFFFFFF});
    rst = 1'b0;
    wait_valid("midrst_wait", FRAME + 100);
    check("midrst_left", $signed(pcm.left), 64'(1));
    check("midrst_right", $signed(pcm.right), 64'(-1));

    // Random pairs under random backpressure.
    for (int i = 0; i < 6; i++) tx_q.push_back({24'($urandom), 24'($urandom)});
    for (int i = 0; i < 6 * FRAME; i++) begin
      pcm.ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    pcm.ready = 1'b1;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
